// File: rtl/mul_sequencer.sv
// Control sequencer for a shift-add multiplier: clear B, then per operand
// bit optionally add A into B and shift B:C right, ITER times.
module mul_sequencer #(
  parameter int ITER = 30,
  parameter int CW   = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic          reg_c_30,
  output logic          busy,
  output logic          done,
  output logic          do_clear_b,
  output logic          do_sum,
  output logic          do_right_shift_bc,
  output logic [CW-1:0] iter_count
);

  // One-hot encoding so every strobe is a flop bit of the state register
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_CLR  = 6'b000010,
    S_CHK  = 6'b000100,
    S_ADD  = 6'b001000,
    S_SHF  = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  localparam logic [CW:0] ITER_W = (CW+1)'(ITER);
  localparam logic [CW:0] ONE_W  = (CW+1)'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_inc;
  logic          w_last;

  // Extra bit keeps the last-iteration compare free of wrap
  assign w_cnt_inc = {1'b0, r_cnt} + ONE_W;
  assign w_last    = (w_cnt_inc >= ITER_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !abort) r_state <= S_CLR;
        end
        S_CLR: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CHK;
            r_cnt   <= '0;
          end
        end
        S_CHK: begin
          if (abort)         r_state <= S_IDLE;
          else if (reg_c_30) r_state <= S_ADD;
          else               r_state <= S_SHF;
        end
        S_ADD: begin
          r_state <= abort ? S_IDLE : S_SHF;
        end
        S_SHF: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= w_cnt_inc[CW-1:0];
            r_state <= w_last ? S_DONE : S_CHK;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy              = ~r_state[0];
  assign do_clear_b        = r_state[1];
  assign do_sum            = r_state[3];
  assign do_right_shift_bc = r_state[4];
  assign done              = r_state[5];
  assign iter_count        = r_cnt;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a shift-add datapath model
// driving the multiplier LSB.
module tb_mul_sequencer;

  localparam int ITER = 30;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic          drv_c;
  logic          use_model;
  logic          reg_c_30;
  logic          busy;
  logic          done;
  logic          do_clear_b;
  logic          do_sum;
  logic          do_right_shift_bc;
  logic [CW-1:0] iter_count;

  logic [29:0] mul_op = '0;
  logic [30:0] mA = 31'd3;
  logic [30:0] mB = '0;
  logic [29:0] mC = '0;

  int checks = 0;
  int fails  = 0;
  int n_clr = 0, n_sum = 0, n_shf = 0;
  int n_done = 0, n_multi = 0, n_seq = 0;
  logic prev_sum = 1'b0;

  always #5 clk = ~clk;

  assign reg_c_30 = use_model ? mC[0] : drv_c;

  mul_sequencer #(.ITER(ITER), .CW(CW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .abort             (abort),
    .reg_c_30          (reg_c_30),
    .busy              (busy),
    .done              (done),
    .do_clear_b        (do_clear_b),
    .do_sum            (do_sum),
    .do_right_shift_bc (do_right_shift_bc),
    .iter_count        (iter_count)
  );

  always @(posedge clk) begin
    if (do_clear_b) n_clr <= n_clr + 1;
    if (do_sum) n_sum <= n_sum + 1;
    if (do_right_shift_bc) n_shf <= n_shf + 1;
    if (done) n_done <= n_done + 1;
    if (int'(do_clear_b) + int'(do_sum) + int'(do_right_shift_bc) > 1)
      n_multi <= n_multi + 1;
    if (prev_sum && !do_right_shift_bc && resetn) n_seq <= n_seq + 1;
    prev_sum <= do_sum;
    if (do_clear_b) begin
      mB <= '0;
      mC <= mul_op;
    end else if (do_sum) begin
      mB <= mB + mA;
    end else if (do_right_shift_bc) begin
      {mB, mC} <= {1'b0, mB, mC[29:1]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit repulse, output int lat);
    int n;
    lat = -1;
    n = 0;
    start = 1'b1;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      start = repulse && (n == 10 || n == 30);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  int lat, s_clr, s_sum, s_shf, s_done, n;
  bit found;

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    drv_c = 1'b0; use_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_clr", 64'(do_clear_b), 64'd0);
    chk("rst_sum", 64'(do_sum), 64'd0);
    chk("rst_shf", 64'(do_right_shift_bc), 64'd0);
    chk("rst_cnt", 64'(iter_count), 64'd0);
    resetn = 1'b1;

    // all-zero multiplier, start on first edge out of reset
    s_clr = n_clr; s_sum = n_sum; s_shf = n_shf; s_done = n_done;
    run_op(1'b0, lat);
    chk("z_lat", 64'(lat), 64'd62);
    chk("z_clr", 64'(n_clr - s_clr), 64'd1);
    chk("z_sum", 64'(n_sum - s_sum), 64'd0);
    chk("z_shf", 64'(n_shf - s_shf), 64'd30);
    chk("z_done", 64'(n_done - s_done), 64'd1);
    chk("z_cnt", 64'(iter_count), 64'd30);
    chk("z_busy", 64'(busy), 64'd0);

    // all-ones multiplier, started in the cycle right after DONE
    drv_c = 1'b1;
    s_clr = n_clr; s_sum = n_sum; s_shf = n_shf;
    run_op(1'b0, lat);
    chk("o_lat", 64'(lat), 64'd92);
    chk("o_clr", 64'(n_clr - s_clr), 64'd1);
    chk("o_sum", 64'(n_sum - s_sum), 64'd30);
    chk("o_shf", 64'(n_shf - s_shf), 64'd30);
    chk("o_cnt", 64'(iter_count), 64'd30);
    drv_c = 1'b0;

    // datapath model: 3 * 0x2AAAAAAA
    use_model = 1'b1;
    mul_op = 30'h2AAAAAAA;
    s_sum = n_sum; s_shf = n_shf;
    run_op(1'b0, lat);
    chk("m_lat", 64'(lat), 64'd77);
    chk("m_sum", 64'(n_sum - s_sum), 64'd15);
    chk("m_shf", 64'(n_shf - s_shf), 64'd30);
    chk("m_prod", 64'({mB, mC}), 64'h7FFFFFFE);
    use_model = 1'b0;

    // abort in the shift of the iteration with iter_count=10
    s_clr = n_clr; s_shf = n_shf; s_done = n_done;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (do_right_shift_bc && iter_count == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    chk("ab_found", 64'(found), 64'd1);
    abort = 1'b1;
    #1;
    chk("ab_shf_now", 64'(do_right_shift_bc), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_cnt", 64'(iter_count), 64'd10);
    chk("ab_shf_n", 64'(n_shf - s_shf), 64'd11);
    chk("ab_clr_n", 64'(n_clr - s_clr), 64'd1);
    run_op(1'b0, lat);
    chk("ab_relat", 64'(lat), 64'd62);
    chk("ab_done_n", 64'(n_done - s_done), 64'd1);

    // start+abort together in IDLE, then start re-pulsed while busy
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_cnt", 64'(iter_count), 64'd30);
    s_clr = n_clr; s_shf = n_shf; s_done = n_done;
    run_op(1'b1, lat);
    chk("rp_lat", 64'(lat), 64'd62);
    chk("rp_clr", 64'(n_clr - s_clr), 64'd1);
    chk("rp_shf", 64'(n_shf - s_shf), 64'd30);
    chk("rp_done", 64'(n_done - s_done), 64'd1);
    chk("rp_busy", 64'(busy), 64'd0);

    // reset while in ADD
    drv_c = 1'b1;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (do_sum) begin
        found = 1'b1;
        break;
      end
    end
    chk("rs_found", 64'(found), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rs_sum", 64'(do_sum), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_cnt", 64'(iter_count), 64'd0);
    s_done = n_done;
    #2;
    resetn = 1'b1;
    n = 0;
    repeat (100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rs_nodone", 64'(n_done - s_done), 64'd0);
    chk("rs_idle", 64'(busy), 64'd0);
    drv_c = 1'b0;

    chk("onehot", 64'(n_multi), 64'd0);
    chk("sum_shf", 64'(n_seq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL use a single clock; reset is asynchronous, active-low: ports clk, resetn.
REQ-002 The block SHALL have parameter ITER, default 30, meaning the number of multiply iterations (one per operand bit).
REQ-003 The block SHALL have parameter CW, default 5, meaning the iteration counter width; the requirement is 2^CW > ITER.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port resetn  input  1  async active-low reset.
REQ-006 The block SHALL have port start  input  1  request one multiply; sampled only in IDLE.
REQ-007 The block SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-008 The block SHALL have port reg_c_30  input  1  multiplier LSB from the arithmetic unit.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port do_clear_b  output  1  clear strobe for the B register.
REQ-012 The block SHALL have port do_sum  output  1  add strobe, B <= A + B.
REQ-013 The block SHALL have port do_right_shift_bc  output  1  shift-right strobe for B:C.
REQ-014 The block SHALL have port iter_count  output  CW  completed iterations.

Function
REQ-015 The block SHALL implement states IDLE, CLR, CHK, ADD, SHF, DONE.
REQ-016 All strobes and done SHALL be a Moore decode of state:
  - CLR: do_clear_b
  - ADD: do_sum
  - SHF: do_right_shift_bc
  - DONE: done
  - every other state: all of these 0.
REQ-017 At most one do_* strobe SHALL be high in any cycle.
REQ-018 Each do_* strobe and done SHALL be high for exactly one cycle per assertion.
REQ-019 The block SHALL make these transitions:
  - IDLE -> CLR when start=1 and abort=0; otherwise stay in IDLE.
  - CLR -> CHK, and iter_count <= 0.
  - CHK -> ADD if reg_c_30=1, else CHK -> SHF; no strobe is issued in CHK.
  - ADD -> SHF.
  - SHF -> CHK if iter_count+1 < ITER, else SHF -> DONE; in both cases iter_count <= iter_count+1.
  - DONE -> IDLE.
REQ-020 reg_c_30 SHALL be sampled only in CHK; its value in all other states SHALL be ignored.
REQ-021 Latency SHALL be counted from the start-accept edge (cycle 0): done is high in cycle 2*ITER+2+k, where k = number of CHK samples with reg_c_30=1.
REQ-022 With ITER=30, that latency SHALL range from 62 to 92 cycles.
REQ-023 start while busy=1 SHALL be ignored, neither queued nor stretching the operation.
REQ-024 start and abort high in the same IDLE cycle SHALL leave the block in IDLE; abort wins.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
REQ-026 On abort, the strobe belonging to the current state SHALL still be issued in that cycle.
REQ-027 An aborted operation SHALL produce no done pulse.
REQ-028 An aborted operation SHALL leave iter_count frozen at its value at the abort.
REQ-029 abort in DONE SHALL have no effect: done still pulses and the next state is IDLE.
REQ-030 iter_count SHALL hold its final value (ITER after completion) until the next CLR.
REQ-031 iter_count SHALL never wrap within one operation.
REQ-032 A start in the cycle immediately after DONE (state IDLE) SHALL be accepted.

Reset
REQ-033 While resetn=0, independent of clk, the block SHALL force state to IDLE and iter_count to 0.
REQ-034 While resetn=0, busy, done, do_clear_b, do_sum and do_right_shift_bc SHALL all be 0.
REQ-035 Reset mid-operation SHALL drop all strobes in the same cycle and SHALL produce no done pulse.
REQ-036 The first start SHALL be accepted on the first rising edge with resetn=1.

Verification
REQ-037 The bench SHALL cover: reg_c_30 held 0, start pulse -> 1 do_clear_b, 0 do_sum, 30 do_right_shift_bc, done at cycle 62, iter_count=30.
REQ-038 The bench SHALL cover: reg_c_30 held 1 -> 30 do_sum, each followed next cycle by do_right_shift_bc, done at cycle 92.
REQ-039 The bench SHALL cover: reg_c_30 driven from a model with multiplier 0x2AAAAAAA and A=3 -> 15 do_sum, done at cycle 77, model product B:C = 3*0x2AAAAAAA.
REQ-040 The bench SHALL cover: abort asserted in iteration 10 (state SHF) -> that shift issued, IDLE next cycle, iter_count=10, no done, start 1 cycle later accepted.
REQ-041 The bench SHALL cover: start re-pulsed while busy, and start+abort together in IDLE -> no effect on the sequence or on strobe count.
REQ-042 The bench SHALL cover: resetn low in state ADD -> do_sum low immediately, busy=0, iter_count=0, no done after release.
